// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: FSM states, access kinds and
// the instruction substituted into IR when a fetch times out.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } kind_e;

  // MOV R0,R0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'hE1A00000;

endpackage

// File: rtl/mem_access_unit_wait_timer.sv
// Counts WAIT cycles of one memory access; expired_o flags the last cycle the
// access is allowed to wait before it is aborted.
module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // Saturates at LAST so the count can never wrap past the abort point.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Converts multicycle controller strobes into a req/ack memory transaction,
// owns IR and the Data register, stalls the controller and bounds each access.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int                 WIDTH     = 32,
  parameter int                 TIMEOUT   = 16,
  parameter logic [WIDTH-1:0]   NOP_INSTR = WIDTH'(NOP_INSTR_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IRWrite,
  input  logic             MemWrite,
  input  logic             AdrSrc,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] Adr,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] Instr,
  output logic [WIDTH-1:0] Data,
  output logic             Stall,
  output logic             BusErr,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic             buserr_q, buserr_d;

  logic fetch, store, load, req;
  logic expired;

  assign fetch = IRWrite;
  assign store = MemWrite & ~IRWrite;
  assign load  = AdrSrc & ~MemWrite & ~IRWrite;
  assign req   = fetch | store | load;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_q != WAIT),
    .enable_i  ((state_q == WAIT) && !mem_ack),
    .expired_o (expired)
  );

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    instr_d  = instr_q;
    data_d   = data_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    req_d    = req_q;
    we_d     = we_q;
    buserr_d = buserr_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = fetch ? PC : Adr;
          we_d    = store;
          wdata_d = WriteData;
          kind_d  = fetch ? FETCH : (store ? STORE : LOAD);
          req_d   = 1'b1;
          state_d = WAIT;
          // Simultaneous fetch and store strobes: fetch proceeds, error flagged.
          if (IRWrite && MemWrite) begin
            buserr_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          if (kind_q == FETCH) instr_d = mem_rdata;
          if (kind_q == LOAD)  data_d  = mem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (expired) begin
          if (kind_q == FETCH) instr_d = NOP_INSTR;
          if (kind_q == LOAD)  data_d  = '0;
          buserr_d = 1'b1;
          req_d    = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      kind_q   <= FETCH;
      instr_q  <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      instr_q  <= instr_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      req_q    <= req_d;
      we_q     <= we_d;
      buserr_q <= buserr_d;
    end
  end

  assign Stall     = reset & (((state_q == IDLE) & req) | (state_q == WAIT));
  assign Instr     = instr_q;
  assign Data      = data_q;
  assign BusErr    = buserr_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a transaction-level model predicts
// stall length, address, IR/Data contents and the sticky bus error per access.
module tb_mem_access_unit;

  localparam int          WIDTH   = 32;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] NOP     = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        IRWrite = 1'b0, MemWrite = 1'b0, AdrSrc = 1'b0;
  logic [31:0] PC = '0, Adr = '0, WriteData = '0;
  logic [31:0] Instr, Data;
  logic        Stall, BusErr, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level reference state.
  logic [31:0] mInstr = '0, mData = '0;
  logic        mBusErr = 1'b0;
  int          expStall;
  logic        expWe;
  logic [31:0] expAddr;

  // Observations gathered by the driver.
  int          obsStall, obsWaits;
  logic        obsStable, obsWe;
  logic [31:0] obsAddr, obsWdata, obsInstr, obsData;

  always #5 clk = ~clk;

  mem_access_unit #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .IRWrite   (IRWrite),
    .MemWrite  (MemWrite),
    .AdrSrc    (AdrSrc),
    .PC        (PC),
    .Adr       (Adr),
    .WriteData (WriteData),
    .Instr     (Instr),
    .Data      (Data),
    .Stall     (Stall),
    .BusErr    (BusErr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  // One access as the reference sees it: ack after ackAt WAIT cycles
  // (0 or beyond TIMEOUT means the access is aborted after TIMEOUT cycles).
  function automatic void modelAccess(input bit irw, input bit mw, input int ackAt,
                                      input logic [31:0] rdata, input logic [31:0] pc,
                                      input logic [31:0] adr);
    bit acked;
    acked    = (ackAt >= 1) && (ackAt <= TIMEOUT);
    expStall = 1 + (acked ? ackAt : TIMEOUT);
    expWe    = mw && !irw;
    expAddr  = irw ? pc : adr;
    if (irw) mInstr = acked ? rdata : NOP;
    else if (!mw) mData = acked ? rdata : 32'h0;
    if (!acked || (irw && mw)) mBusErr = 1'b1;
  endfunction

  // Plays controller and memory for one access; holds strobes while stalled.
  task automatic runAccess(input bit irw, input bit mw, input bit as,
                           input logic [31:0] pc, input logic [31:0] adr,
                           input logic [31:0] wd, input int ackAt,
                           input logic [31:0] rdata);
    bit first;
    @(posedge clk); #1;
    IRWrite = irw; MemWrite = mw; AdrSrc = as;
    PC = pc; Adr = adr; WriteData = wd; mem_ack = 1'b0;
    obsStall = 0; obsWaits = 0; obsStable = 1'b1; first = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!Stall) break;
      obsStall++;
      if (mem_req) begin
        if (first) begin
          obsAddr = mem_addr; obsWe = mem_we; obsWdata = mem_wdata;
        end else if (mem_addr !== obsAddr || mem_we !== obsWe || mem_wdata !== obsWdata) begin
          obsStable = 1'b0;
        end
        first = 1'b0;
        obsWaits++;
        mem_ack   = (obsWaits == ackAt);
        mem_rdata = mem_ack ? rdata : $urandom;
      end else begin
        mem_ack = 1'b0;
      end
    end
    mem_ack  = 1'b0;
    obsInstr = Instr;
    obsData  = Data;
    @(posedge clk); #1;
    IRWrite = 1'b0; MemWrite = 1'b0; AdrSrc = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; IRWrite = 1'b1; AdrSrc = 1'b1; PC = $urandom; Adr = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (Stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall got %b want 0", Stall); end
    vectors++; if (Instr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_instr got %h want 0", Instr); end
    vectors++; if (Data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_data got %h want 0", Data); end
    vectors++; if (BusErr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_buserr got %b want 0", BusErr); end
    vectors++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req_we got %b%b want 00", mem_req, mem_we); end
    vectors++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_addr_wdata got %h/%h want 0/0", mem_addr, mem_wdata); end
    @(posedge clk); #1;
    IRWrite = 1'b0; AdrSrc = 1'b0; reset = 1'b1;
    mInstr = '0; mData = '0; mBusErr = 1'b0;
  endtask

  task automatic test_zero_wait_fetch;
    modelAccess(1, 0, 1, 32'hE0855004, 32'h8, 32'h0);
    runAccess(1, 0, 0, 32'h8, 32'h0, 32'h0, 1, 32'hE0855004);
    vectors++; if (obsAddr !== 32'h8) begin miscompares++; $display("[TB] FAIL fetch0_addr got %h want 8", obsAddr); end
    vectors++; if (obsWe !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch0_we got %b want 0", obsWe); end
    vectors++; if (obsStall != 2) begin miscompares++; $display("[TB] FAIL fetch0_stall got %0d want 2", obsStall); end
    vectors++; if (obsInstr !== 32'hE0855004) begin miscompares++; $display("[TB] FAIL fetch0_instr got %h want e0855004", obsInstr); end
    vectors++; if (obsData !== mData) begin miscompares++; $display("[TB] FAIL fetch0_data got %h want %h", obsData, mData); end
  endtask

  task automatic test_load_wait;
    modelAccess(0, 0, 4, 32'h2A, 32'h0, 32'h60);
    runAccess(0, 0, 1, $urandom, 32'h60, $urandom, 4, 32'h2A);
    vectors++; if (obsStall != 5) begin miscompares++; $display("[TB] FAIL load_stall got %0d want 5", obsStall); end
    vectors++; if (obsData !== 32'h2A) begin miscompares++; $display("[TB] FAIL load_data got %h want 2a", obsData); end
    vectors++; if (obsInstr !== mInstr) begin miscompares++; $display("[TB] FAIL load_instr got %h want %h", obsInstr, mInstr); end
    vectors++; if (obsAddr !== 32'h60 || !obsStable) begin miscompares++; $display("[TB] FAIL load_addr got %h stable %b want 60 stable 1", obsAddr, obsStable); end
  endtask

  task automatic test_store;
    modelAccess(0, 1, 2, 32'h0, 32'h0, 32'h54);
    runAccess(0, 1, 1, $urandom, 32'h54, 32'hDEADBEEF, 2, $urandom);
    vectors++; if (obsWe !== 1'b1 || !obsStable) begin miscompares++; $display("[TB] FAIL store_we got %b stable %b want 1 stable 1", obsWe, obsStable); end
    vectors++; if (obsWdata !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL store_wdata got %h want deadbeef", obsWdata); end
    vectors++; if (obsInstr !== mInstr || obsData !== mData) begin miscompares++; $display("[TB] FAIL store_regs got %h/%h want %h/%h", obsInstr, obsData, mInstr, mData); end
    vectors++; if (BusErr !== 1'b0) begin miscompares++; $display("[TB] FAIL store_buserr got %b want 0", BusErr); end
  endtask

  task automatic test_timeout;
    logic [31:0] rd;
    modelAccess(1, 0, 0, 32'h0, 32'h100, 32'h0);
    runAccess(1, 0, 0, 32'h100, 32'h0, 32'h0, 0, 32'h0);
    vectors++; if (obsWaits != TIMEOUT) begin miscompares++; $display("[TB] FAIL timeout_waits got %0d want %0d", obsWaits, TIMEOUT); end
    vectors++; if (obsInstr !== NOP) begin miscompares++; $display("[TB] FAIL timeout_instr got %h want %h", obsInstr, NOP); end
    vectors++; if (BusErr !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_buserr got %b want 1", BusErr); end
    rd = $urandom;
    modelAccess(0, 0, 1, rd, 32'h0, 32'h70);
    runAccess(0, 0, 1, 32'h0, 32'h70, 32'h0, 1, rd);
    vectors++; if (obsData !== rd || BusErr !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_sticky got %h/%b want %h/1", obsData, BusErr, rd); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++) begin
      int k, ackAt;
      bit irw, mw, as;
      logic [31:0] pc, adr, wd, rd;
      k = $urandom_range(0, 2);
      irw = (k == 0); mw = (k == 2); as = (k == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      ackAt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
      pc = $urandom; adr = $urandom; wd = $urandom; rd = $urandom;
      modelAccess(irw, mw, ackAt, rd, pc, adr);
      runAccess(irw, mw, as, pc, adr, wd, ackAt, rd);
      vectors++; if (obsStall != expStall) begin miscompares++; $display("[TB] FAIL rand%0d_stall got %0d want %0d", i, obsStall, expStall); end
      vectors++; if (obsAddr !== expAddr || obsWe !== expWe) begin miscompares++; $display("[TB] FAIL rand%0d_addr got %h/%b want %h/%b", i, obsAddr, obsWe, expAddr, expWe); end
      vectors++; if (expWe && obsWdata !== wd) begin miscompares++; $display("[TB] FAIL rand%0d_wdata got %h want %h", i, obsWdata, wd); end
      vectors++; if (obsInstr !== mInstr) begin miscompares++; $display("[TB] FAIL rand%0d_instr got %h want %h", i, obsInstr, mInstr); end
      vectors++; if (obsData !== mData) begin miscompares++; $display("[TB] FAIL rand%0d_data got %h want %h", i, obsData, mData); end
      vectors++; if (BusErr !== mBusErr) begin miscompares++; $display("[TB] FAIL rand%0d_buserr got %b want %b", i, BusErr, mBusErr); end
    end
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] rd;
    @(posedge clk); #1;
    IRWrite = 1'b0; MemWrite = 1'b0; AdrSrc = 1'b1; Adr = 32'h80; mem_ack = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (Stall !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_stall got %b want 0", Stall); end
    @(posedge clk);
    @(negedge clk);
    vectors++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || BusErr !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_outputs got %b/%h/%b want 0/0/0", mem_req, mem_addr, BusErr); end
    vectors++; if (Instr !== 32'h0 || Data !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_regs got %h/%h want 0/0", Instr, Data); end
    AdrSrc = 1'b0; reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0;
    vectors++; if (mem_req !== 1'b0 || Data !== 32'h0 || Instr !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_lateack got %b/%h/%h want 0/0/0", mem_req, Data, Instr); end
    mInstr = '0; mData = '0; mBusErr = 1'b0;
    rd = $urandom;
    modelAccess(1, 0, 2, rd, 32'h4, 32'h0);
    runAccess(1, 0, 0, 32'h4, 32'h0, 32'h0, 2, rd);
    vectors++; if (obsInstr !== rd || obsStall != 3) begin miscompares++; $display("[TB] FAIL midrst_fetch got %h/%0d want %h/3", obsInstr, obsStall, rd); end
  endtask

  task automatic test_conflict;
    logic [31:0] pc, rd;
    pc = $urandom; rd = $urandom;
    modelAccess(1, 1, 1, rd, pc, 32'hA0);
    runAccess(1, 1, 1, pc, 32'hA0, $urandom, 1, rd);
    vectors++; if (obsWe !== 1'b0 || obsAddr !== pc) begin miscompares++; $display("[TB] FAIL conflict_fetch got %b/%h want 0/%h", obsWe, obsAddr, pc); end
    vectors++; if (obsInstr !== rd) begin miscompares++; $display("[TB] FAIL conflict_instr got %h want %h", obsInstr, rd); end
    vectors++; if (BusErr !== 1'b1) begin miscompares++; $display("[TB] FAIL conflict_buserr got %b want 1", BusErr); end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait_fetch();
    test_load_wait();
    test_store();
    test_timeout();
    test_random();
    test_reset_mid_access();
    test_conflict();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
